// File: rtl/handshake_ff_input.sv
// Receiving end of a valid/ready byte stream: registered o_ready, 2-entry skid buffer,
// and an incrementing-sequence checker that counts beats and latches the first error.
module handshake_ff_input #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16,
    parameter int SEQ_START   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       i_value,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [WIDTH-1:0]       o_value,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_error,
    output logic [WIDTH-1:0]       o_error_value
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [WIDTH-1:0]       r_main;
    logic [WIDTH-1:0]       r_skid;
    logic                   r_ready;
    logic                   r_valid;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_error;
    logic [WIDTH-1:0]       r_error_value;
    logic [WIDTH-1:0]       r_expected;
    logic                   w_accept;
    logic                   w_take;

    assign w_accept = i_valid && r_ready;
    assign w_take   = r_valid && i_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_next = S_ONE;
            S_ONE: begin
                if (w_accept && !w_take)      w_next = S_FULL;
                else if (!w_accept && w_take) w_next = S_EMPTY;
            end
            S_FULL:  if (w_take) w_next = S_ONE;
            default: w_next = S_EMPTY;
        endcase
    end

    // Ready and valid are registered from the next state, so no input reaches them combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_EMPTY;
            r_main        <= '0;
            r_skid        <= '0;
            r_ready       <= 1'b0;
            r_valid       <= 1'b0;
            r_count       <= '0;
            r_error       <= 1'b0;
            r_error_value <= '0;
            r_expected    <= WIDTH'(SEQ_START);
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != S_FULL);
            r_valid <= (w_next != S_EMPTY);

            case (r_state)
                S_EMPTY: if (w_accept) r_main <= i_value;
                S_ONE: begin
                    if (w_accept && w_take) r_main <= i_value;
                    else if (w_accept)      r_skid <= i_value;
                end
                S_FULL:  if (w_take) r_main <= r_skid;
                default: ;
            endcase

            // Expected value resyncs to every accepted beat, so one bad beat flags once.
            if (w_accept) begin
                r_count    <= r_count + 1'b1;
                r_expected <= i_value + 1'b1;
                if ((i_value != r_expected) && !r_error) begin
                    r_error       <= 1'b1;
                    r_error_value <= i_value;
                end
            end
        end
    end

    assign o_ready       = r_ready;
    assign o_valid       = r_valid;
    assign o_value       = r_main;
    assign o_count       = r_count;
    assign o_error       = r_error;
    assign o_error_value = r_error_value;

endmodule

// File: doc/handshake_ff_input.md
Name: handshake_ff_input

Overview:
- Receiving end of the valid/ready byte stream driven by handshake_ff_output.
- Accepts beats on i_value/i_valid and returns a flip-flop-driven o_ready; no combinational path from any input to o_ready.
- Holds accepted data in a 2-entry skid buffer and forwards it to a local sink on o_value/o_valid/i_ready, sustaining one beat per cycle.
- Checks the incoming stream against the incrementing sequence the transmitter produces and reports beat count and first error.

Parameters:
- WIDTH, 8, data width of i_value/o_value/o_error_value.
- COUNT_WIDTH, 16, width of o_count.
- SEQ_START, 1, first expected value after reset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- i_value  input  WIDTH  upstream data.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  upstream ready; registered.
- o_value  output  WIDTH  downstream data; registered.
- o_valid  output  1  downstream valid; registered.
- i_ready  input  1  downstream ready.
- o_count  output  COUNT_WIDTH  number of accepted upstream beats; wraps.
- o_error  output  1  sticky sequence-mismatch flag.
- o_error_value  output  WIDTH  value of the first mismatching beat.

Behaviour:
- Reset: o_ready=0, o_valid=0, o_value=0, o_count=0, o_error=0, o_error_value=0, state EMPTY, expected=SEQ_START, skid register=0. Reset is asynchronous on assert and takes effect mid-transfer; any buffered data is discarded.
- o_ready rises at the first clock edge after reset deasserts.
- Upstream accept is i_valid && o_ready at a rising edge. Downstream take is o_valid && i_ready at a rising edge.
- o_ready is a register loaded with (next_state != FULL).
- The upstream side must hold i_valid/i_value until accepted. The block does not check this.
- States:
  - EMPTY: o_valid=0. On accept: main<=i_value, go to ONE.
  - ONE: o_valid=1, o_value=main.
    - accept and take: main<=i_value, stay ONE.
    - accept only: skid<=i_value, go to FULL.
    - take only: go to EMPTY.
    - neither: hold.
  - FULL: o_ready=0, so no accept is possible. On take: main<=skid, go to ONE. Otherwise hold.
- Latency: a beat accepted at edge N appears on o_value/o_valid after edge N when the buffer is EMPTY.
- Ordering is FIFO; no beat is dropped or duplicated.
- Full throughput: with i_valid=1 and i_ready=1 held, one beat transfers per cycle on each side with no bubbles.
- While o_valid=1 and i_ready=0, o_value stays stable.
- Checker acts on every accept:
  - o_count increments by 1 and wraps from all-ones to 0.
  - If i_value != expected and o_error=0: o_error<=1 and o_error_value<=i_value.
  - expected <= i_value+1 (mod 2^WIDTH) after every accept, whether or not it matched. A single corrupted beat therefore raises exactly one error, and following correct beats do not re-flag.
  - expected wraps 8'hFF -> 8'h00.
- o_error stays set until reset; later mismatches do not change o_error_value.

Test Plan:
- Reset then idle: reset high 10 cycles, then low -> all outputs 0 during reset; o_ready=1 one edge after release; o_valid stays 0 with i_valid=0.
- Streaming: send 1..100 back-to-back, i_ready held 1 -> o_value sequence 1..100, one per cycle; o_ready never drops; o_count=100; o_error=0.
- Backpressure: i_ready=0, send 8'h01, 8'h02 -> state FULL, o_ready=0, o_value=8'h01; raise i_ready for 1 cycle -> o_value=8'h02, o_ready=1 next cycle; no beat lost.
- Random stalls: random 0..10-cycle gaps on both i_valid and i_ready, 100 beats -> downstream receives exactly 1..100 in order; o_count=100.
- Sequence error and wrap: send 1,2,7,8 -> o_error=1, o_error_value=8'h07, no further error. Separately send 8'hFE,8'hFF,8'h00 with SEQ_START=8'hFE -> o_error=0.
- Reset mid-operation: assert reset while FULL -> o_valid=0 and o_ready=0 immediately (asynchronous); after release, first beat 8'h01 is accepted with o_count=1 and o_error=0.
